// File: rtl/car_motion_ctrl.sv
// Car position/heading owner for the animation block: accepts one-step move
// requests, checks screen bounds and two collision-ROM corner pixels, then commits or blocks.
module car_motion_ctrl #(
  parameter logic [7:0] START_X = 8'd10,
  parameter logic [6:0] START_Y = 7'd10,
  parameter int         CAR_W   = 8,
  parameter int         CAR_H   = 8,
  parameter int         STEP    = 1,
  parameter int         SCR_W   = 160,
  parameter int         SCR_H   = 120
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ldXY,
  input  logic        key_up,
  input  logic        key_right,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        wallQ,
  output logic [14:0] wallAddr,
  output logic [7:0]  nextX,
  output logic [6:0]  nextY,
  output logic [2:0]  dir,
  output logic        moveDone,
  output logic        blocked
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CHK, DONE} state_t;

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;

  state_t      state, stateNext;
  logic [7:0]  cxReg;
  logic [6:0]  cyReg;
  logic [14:0] addrBReg;
  logic        hitA;

  logic        keyAny;
  logic        accept;
  logic [2:0]  reqDir;
  logic [7:0]  cx, xRight;
  logic [6:0]  cy, yBottom;
  logic        outOfBounds;
  logic [14:0] addrA, addrB;

  // y*160 + x built from shifts so no multiplier is needed.
  function automatic logic [14:0] pixAddr(input logic [7:0] px, input logic [6:0] py);
    logic [14:0] yWide;
    yWide = {8'd0, py};
    return (yWide << 7) + (yWide << 5) + {7'd0, px};
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    keyAny      = key_up | key_right | key_down | key_left;
    accept      = (state == IDLE) && ldXY && keyAny;
    reqDir      = key_up ? DIR_UP : key_right ? DIR_RIGHT : key_down ? DIR_DOWN : DIR_LEFT;
    cx          = nextX;
    cy          = nextY;
    outOfBounds = 1'b0;
    case (reqDir)
      DIR_UP: begin
        outOfBounds = {2'b00, nextY} < 9'(STEP);
        cy          = nextY - 7'(STEP);
      end
      DIR_RIGHT: begin
        outOfBounds = ({1'b0, nextX} + 9'(STEP + CAR_W)) > 9'(SCR_W);
        cx          = nextX + 8'(STEP);
      end
      DIR_DOWN: begin
        outOfBounds = ({2'b00, nextY} + 9'(STEP + CAR_H)) > 9'(SCR_H);
        cy          = nextY + 7'(STEP);
      end
      default: begin
        outOfBounds = {1'b0, nextX} < 9'(STEP);
        cx          = nextX - 8'(STEP);
      end
    endcase

    // Leading-edge corners of the candidate footprint.
    xRight  = cx + 8'(CAR_W - 1);
    yBottom = cy + 7'(CAR_H - 1);
    case (reqDir)
      DIR_UP:    begin addrA = pixAddr(cx, cy);          addrB = pixAddr(xRight, cy);      end
      DIR_RIGHT: begin addrA = pixAddr(xRight, cy);      addrB = pixAddr(xRight, yBottom); end
      DIR_DOWN:  begin addrA = pixAddr(cx, yBottom);     addrB = pixAddr(xRight, yBottom); end
      default:   begin addrA = pixAddr(cx, cy);          addrB = pixAddr(cx, yBottom);     end
    endcase
  end

  always_comb begin
    stateNext = state;
    moveDone  = 1'b0;
    case (state)
      IDLE:    if (accept) stateNext = outOfBounds ? DONE : RD_A;
      RD_A:    stateNext = RD_B;
      RD_B:    stateNext = CHK;
      CHK:     stateNext = DONE;
      DONE: begin
        moveDone  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      nextX    <= START_X;
      nextY    <= START_Y;
      dir      <= DIR_RIGHT;
      wallAddr <= '0;
      blocked  <= 1'b0;
      cxReg    <= START_X;
      cyReg    <= START_Y;
      addrBReg <= '0;
      hitA     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          // Heading follows the key even when the move ends up blocked.
          dir      <= reqDir;
          cxReg    <= cx;
          cyReg    <= cy;
          addrBReg <= addrB;
          if (outOfBounds) blocked  <= 1'b1;
          else             wallAddr <= addrA;
        end
        RD_A: wallAddr <= addrBReg;
        RD_B: hitA     <= wallQ;
        CHK: begin
          if (hitA | wallQ) begin
            blocked <= 1'b1;
          end else begin
            nextX   <= cxReg;
            nextY   <= cyReg;
            blocked <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl: the bench drives wallQ cycle by cycle in place of the ROM
// and compares outputs against hand-computed values one time unit after each rising edge.
module tb_car_motion_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ldXY;
  logic        key_up, key_right, key_down, key_left;
  logic        wallQ;
  logic [14:0] wallAddr;
  logic [7:0]  nextX;
  logic [6:0]  nextY;
  logic [2:0]  dir;
  logic        moveDone;
  logic        blocked;

  int compared   = 0;
  int mismatched = 0;

  car_motion_ctrl dut (
    .clock(clock), .resetn(resetn), .ldXY(ldXY),
    .key_up(key_up), .key_right(key_right), .key_down(key_down), .key_left(key_left),
    .wallQ(wallQ), .wallAddr(wallAddr), .nextX(nextX), .nextY(nextY),
    .dir(dir), .moveDone(moveDone), .blocked(blocked)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    ldXY = 0; key_up = 0; key_right = 0; key_down = 0; key_left = 0; wallQ = 0;
  endtask

  task automatic apply_reset;
    resetn = 0;
    clear_inputs();
    tick();
    tick();
    resetn = 1;
  endtask

  task automatic test_reset;
    apply_reset();
    if (nextX !== 8'd10) begin $display("FAIL reset_nextX got %0d want 10", nextX); mismatched++; end compared++;
    if (nextY !== 7'd10) begin $display("FAIL reset_nextY got %0d want 10", nextY); mismatched++; end compared++;
    if (dir !== 3'd1) begin $display("FAIL reset_dir got %0d want 1", dir); mismatched++; end compared++;
    if (wallAddr !== 15'd0) begin $display("FAIL reset_wallAddr got %0d want 0", wallAddr); mismatched++; end compared++;
    if (moveDone !== 1'b0) begin $display("FAIL reset_moveDone got %b want 0", moveDone); mismatched++; end compared++;
    if (blocked !== 1'b0) begin $display("FAIL reset_blocked got %b want 0", blocked); mismatched++; end compared++;
  endtask

  task automatic test_free_right;
    apply_reset();
    key_right = 1; ldXY = 1;
    tick(); // cycle 1
    if (wallAddr !== 15'd1618) begin $display("FAIL right_addrA got %0d want 1618", wallAddr); mismatched++; end compared++;
    if (dir !== 3'd1) begin $display("FAIL right_dir got %0d want 1", dir); mismatched++; end compared++;
    ldXY = 0; key_right = 0; // key release after acceptance must not matter
    tick(); // cycle 2
    if (wallAddr !== 15'd2738) begin $display("FAIL right_addrB got %0d want 2738", wallAddr); mismatched++; end compared++;
    wallQ = 0;
    tick(); // cycle 3
    if (nextX !== 8'd10) begin $display("FAIL right_early_nextX got %0d want 10", nextX); mismatched++; end compared++;
    if (moveDone !== 1'b0) begin $display("FAIL right_early_done got %b want 0", moveDone); mismatched++; end compared++;
    tick(); // cycle 4
    if (nextX !== 8'd11) begin $display("FAIL right_nextX got %0d want 11", nextX); mismatched++; end compared++;
    if (nextY !== 7'd10) begin $display("FAIL right_nextY got %0d want 10", nextY); mismatched++; end compared++;
    if (moveDone !== 1'b1) begin $display("FAIL right_done got %b want 1", moveDone); mismatched++; end compared++;
    if (blocked !== 1'b0) begin $display("FAIL right_blocked got %b want 0", blocked); mismatched++; end compared++;
    tick(); // cycle 5
    if (moveDone !== 1'b0) begin $display("FAIL right_done_pulse got %b want 0", moveDone); mismatched++; end compared++;
  endtask

  // hitCycle selects which ROM read reports a wall: 2 = corner A, 3 = corner B.
  task automatic test_wall_hit(input int hitCycle);
    apply_reset();
    key_right = 1; ldXY = 1;
    tick(); // cycle 1
    ldXY = 0;
    tick(); // cycle 2
    wallQ = (hitCycle == 2);
    tick(); // cycle 3
    wallQ = (hitCycle == 3);
    tick(); // cycle 4
    wallQ = 0;
    if (nextX !== 8'd10) begin $display("FAIL hit%0d_nextX got %0d want 10", hitCycle, nextX); mismatched++; end compared++;
    if (nextY !== 7'd10) begin $display("FAIL hit%0d_nextY got %0d want 10", hitCycle, nextY); mismatched++; end compared++;
    if (blocked !== 1'b1) begin $display("FAIL hit%0d_blocked got %b want 1", hitCycle, blocked); mismatched++; end compared++;
    if (dir !== 3'd1) begin $display("FAIL hit%0d_dir got %0d want 1", hitCycle, dir); mismatched++; end compared++;
    if (moveDone !== 1'b1) begin $display("FAIL hit%0d_done got %b want 1", hitCycle, moveDone); mismatched++; end compared++;
    tick(); // cycle 5
    if (blocked !== 1'b1) begin $display("FAIL hit%0d_blocked_hold got %b want 1", hitCycle, blocked); mismatched++; end compared++;
    // A following free move clears blocked.
    ldXY = 1;
    tick();
    ldXY = 0; key_right = 0;
    repeat (3) tick();
    if (nextX !== 8'd11) begin $display("FAIL hit%0d_retry_nextX got %0d want 11", hitCycle, nextX); mismatched++; end compared++;
    if (blocked !== 1'b0) begin $display("FAIL hit%0d_retry_blocked got %b want 0", hitCycle, blocked); mismatched++; end compared++;
    tick();
  endtask

  task automatic test_boundary;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      key_left = 1; ldXY = 1;
      tick();
      ldXY = 0; key_left = 0;
      repeat (4) tick();
    end
    if (nextX !== 8'd0) begin $display("FAIL bound_walk_nextX got %0d want 0", nextX); mismatched++; end compared++;
    if (blocked !== 1'b0) begin $display("FAIL bound_walk_blocked got %b want 0", blocked); mismatched++; end compared++;
    key_left = 1; ldXY = 1;
    tick(); // cycle 1: straight to DONE
    ldXY = 0; key_left = 0;
    if (moveDone !== 1'b1) begin $display("FAIL bound_done got %b want 1", moveDone); mismatched++; end compared++;
    if (blocked !== 1'b1) begin $display("FAIL bound_blocked got %b want 1", blocked); mismatched++; end compared++;
    if (dir !== 3'd3) begin $display("FAIL bound_dir got %0d want 3", dir); mismatched++; end compared++;
    if (wallAddr !== 15'd2720) begin $display("FAIL bound_wallAddr got %0d want 2720", wallAddr); mismatched++; end compared++;
    if (nextX !== 8'd0) begin $display("FAIL bound_nextX got %0d want 0", nextX); mismatched++; end compared++;
    tick(); // cycle 2: IDLE again
    if (moveDone !== 1'b0) begin $display("FAIL bound_done_pulse got %b want 0", moveDone); mismatched++; end compared++;
  endtask

  task automatic test_priority_ignore;
    apply_reset();
    key_up = 1; key_left = 1; ldXY = 1;
    tick(); // cycle 1
    ldXY = 0;
    if (dir !== 3'd0) begin $display("FAIL prio_dir got %0d want 0", dir); mismatched++; end compared++;
    if (wallAddr !== 15'd1450) begin $display("FAIL prio_addrA got %0d want 1450", wallAddr); mismatched++; end compared++;
    tick(); // cycle 2: second request must be dropped
    ldXY = 1;
    if (wallAddr !== 15'd1457) begin $display("FAIL prio_addrB got %0d want 1457", wallAddr); mismatched++; end compared++;
    tick(); // cycle 3
    ldXY = 0; key_up = 0; key_left = 0;
    tick(); // cycle 4
    if (nextY !== 7'd9) begin $display("FAIL prio_nextY got %0d want 9", nextY); mismatched++; end compared++;
    if (nextX !== 8'd10) begin $display("FAIL prio_nextX got %0d want 10", nextX); mismatched++; end compared++;
    if (moveDone !== 1'b1) begin $display("FAIL prio_done got %b want 1", moveDone); mismatched++; end compared++;
    for (int c = 5; c < 10; c++) begin
      tick();
      if (moveDone !== 1'b0) begin $display("FAIL prio_no_second_done cycle %0d got %b want 0", c, moveDone); mismatched++; end compared++;
    end
    // No key held: the request is ignored.
    ldXY = 1;
    tick();
    ldXY = 0;
    for (int c = 0; c < 6; c++) begin
      if (moveDone !== 1'b0) begin $display("FAIL nokey_done cycle %0d got %b want 0", c, moveDone); mismatched++; end compared++;
      tick();
    end
    if (dir !== 3'd0) begin $display("FAIL nokey_dir got %0d want 0", dir); mismatched++; end compared++;
    if (nextY !== 7'd9) begin $display("FAIL nokey_nextY got %0d want 9", nextY); mismatched++; end compared++;
  endtask

  task automatic test_reset_mid_move;
    apply_reset();
    key_right = 1; ldXY = 1;
    tick(); // cycle 1
    ldXY = 0;
    tick(); // cycle 2
    resetn = 0;
    tick();
    if (nextX !== 8'd10) begin $display("FAIL midrst_nextX got %0d want 10", nextX); mismatched++; end compared++;
    if (dir !== 3'd1) begin $display("FAIL midrst_dir got %0d want 1", dir); mismatched++; end compared++;
    if (wallAddr !== 15'd0) begin $display("FAIL midrst_wallAddr got %0d want 0", wallAddr); mismatched++; end compared++;
    if (moveDone !== 1'b0) begin $display("FAIL midrst_done got %b want 0", moveDone); mismatched++; end compared++;
    resetn = 1; key_right = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (moveDone !== 1'b0) begin $display("FAIL midrst_stray_done step %0d got %b want 0", c, moveDone); mismatched++; end compared++;
    end
    if (nextX !== 8'd10) begin $display("FAIL midrst_after_nextX got %0d want 10", nextX); mismatched++; end compared++;
    // Back in IDLE: a down move is accepted right away.
    key_down = 1; ldXY = 1;
    tick(); // cycle 1
    ldXY = 0; key_down = 0;
    if (dir !== 3'd2) begin $display("FAIL down_dir got %0d want 2", dir); mismatched++; end compared++;
    if (wallAddr !== 15'd2890) begin $display("FAIL down_addrA got %0d want 2890", wallAddr); mismatched++; end compared++;
    tick(); // cycle 2
    if (wallAddr !== 15'd2897) begin $display("FAIL down_addrB got %0d want 2897", wallAddr); mismatched++; end compared++;
    tick(); // cycle 3
    tick(); // cycle 4
    if (nextY !== 7'd11) begin $display("FAIL down_nextY got %0d want 11", nextY); mismatched++; end compared++;
    if (moveDone !== 1'b1) begin $display("FAIL down_done got %b want 1", moveDone); mismatched++; end compared++;
    tick();
  endtask

  initial begin
    resetn = 0;
    clear_inputs();
    test_reset();
    test_free_right();
    test_wall_hit(3);
    test_wall_hit(2);
    test_boundary();
    test_priority_ignore();
    test_reset_mid_move();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/car_motion_ctrl.md
# car_motion_ctrl

Upstream stage of the animation block: it owns the car's position and heading and supplies `nextX`, `nextY` and `dir` to the draw/erase engines. On each `ldXY` step request from the animation FSM it reads the held direction key. It checks screen bounds, then probes the 1-bit collision ROM at two leading-edge corner pixels. It then either commits the one-step move or reports the move as blocked.

## Interface
Parameters:
- `START_X`, default 8'd10: reset X (top-left pixel of car).
- `START_Y`, default 7'd10: reset Y.
- `CAR_W`, default 8: car width in pixels.
- `CAR_H`, default 8: car height in pixels.
- `STEP`, default 1: pixels moved per accepted step.
- `SCR_W`, default 160: screen width.
- `SCR_H`, default 120: screen height.

Ports:
- `clock` in 1: single clock, all logic rising-edge.
- `resetn` in 1: synchronous, active-low reset.
- `ldXY` in 1: step request pulse from the animation FSM.
- `key_up`, `key_right`, `key_down`, `key_left` in 1 each: active-high held direction keys.
- `wallQ` in 1: collision ROM data. 1 means wall. Valid the cycle after `wallAddr` is presented.
- `wallAddr` out 15: collision ROM address, y*SCR_W+x.
- `nextX` out 8: committed car X.
- `nextY` out 7: committed car Y.
- `dir` out 3: heading. 0=up, 1=right, 2=down, 3=left. Codes 4–7 are never driven.
- `moveDone` out 1: one-cycle pulse when a step request finishes.
- `blocked` out 1: the last finished request did not move.

## Operation
- Reset values: `nextX`=START_X, `nextY`=START_Y, `dir`=1, `wallAddr`=0, `moveDone`=0, `blocked`=0, state IDLE.
- States are IDLE, RD_A, RD_B, CHK and DONE.
- **IDLE**
  - Acts only on `ldXY`=1. With no key held, the request is ignored: no state change, no `moveDone`.
  - Key priority: up > right > down > left. The winning key is latched as `reqDir`, and `dir` <= `reqDir` immediately, even if the move is later blocked.
  - Candidate position: cx = x±STEP, cy = y±STEP, along the requested axis only.
- **Bounds check** (9-bit unsigned arithmetic, no wrap):
  - left is out of bounds if x < STEP;
  - right is out of bounds if x+STEP+CAR_W > SCR_W;
  - up is out of bounds if y < STEP;
  - down is out of bounds if y+STEP+CAR_H > SCR_H.
  - Out of bounds: go straight to DONE with `blocked`<=1. No ROM reads.
- **Corner pixels A/B** (computed on the candidate position):
  - right: (cx+CAR_W-1, cy) and (cx+CAR_W-1, cy+CAR_H-1);
  - left: (cx, cy) and (cx, cy+CAR_H-1);
  - up: (cx, cy) and (cx+CAR_W-1, cy);
  - down: (cx, cy+CAR_H-1) and (cx+CAR_W-1, cy+CAR_H-1).
- Address = (y<<7)+(y<<5)+x. The maximum, 19199, fits in 15 bits. `wallAddr` is a registered output.
- **RD_A**: `wallAddr`=A. At the end of the cycle, `wallAddr`<=B and the FSM goes to RD_B.
- **RD_B**: register hitA<=`wallQ`. Go to CHK.
- **CHK**: hit = hitA | `wallQ`.
  - If hit: `blocked`<=1 and position is unchanged.
  - Otherwise: `nextX`/`nextY`<=cx/cy and `blocked`<=0.
  - Go to DONE.
- **DONE**: `moveDone`=1 for exactly one cycle, then back to IDLE.
- `blocked` holds its value until the next finished request.
- `ldXY` asserted outside IDLE is ignored. It is not queued.
- Key changes after IDLE has accepted a request have no effect on that request.
- `resetn`=0 in any state: the next edge returns every output to its reset value and abandons any in-flight move, which is not committed.

## Timing
- Let cycle 0 be the IDLE cycle in which `ldXY` is sampled.
- In-bounds request:
  - cycle 1: RD_A, `wallAddr`=A;
  - cycle 2: RD_B, `wallAddr`=B, `wallQ` reflects A;
  - cycle 3: CHK, `wallQ` reflects B;
  - cycle 4: DONE, new `nextX`/`nextY`/`blocked` visible, `moveDone`=1;
  - cycle 5: IDLE, ready for the next request.
- Out-of-bounds request: DONE in cycle 1 with `moveDone`=1. Back in IDLE in cycle 2.
- `dir` changes in cycle 1 in both cases.
- Position outputs never change except at the CHK→DONE edge or on reset.

## Test plan
- **Reset:** hold `resetn`=0 for 2 cycles. Expect `nextX`=10, `nextY`=10, `dir`=1, `wallAddr`=0, `moveDone`=0, `blocked`=0.
- **Free move right:** `key_right`=1, ldXY pulse, `wallQ`=0. Expect `wallAddr`=1618 in cycle 1 and 2738 in cycle 2. In cycle 4: `nextX`=11, `nextY`=10, `moveDone`=1, `blocked`=0.
- **Wall hit:** same stimulus, but `wallQ`=1 only in cycle 3. Expect position to stay 10/10, `blocked`=1, `dir`=1, `moveDone` in cycle 4.
- **Boundary:** after reset, force x=0 with 10 left steps, then `key_left` plus ldXY. Expect `moveDone` in cycle 1, `blocked`=1, `dir`=3, `wallAddr` unchanged, `nextX`=0.
- **Priority and ignore:** `key_up` and `key_left` held together. Expect `dir`=0 and a move to y=9. A second ldXY in cycle 2 produces no second `moveDone`. No keys held plus ldXY produces no `moveDone`.
- **Reset mid-move:** assert `resetn`=0 in cycle 2 of a free right move. Expect `nextX`=10, `dir`=1, state IDLE, and no `moveDone` pulse.
